inst_fetch_unit: RTL and testbench

Instruction fetch initiator that drives the single-cycle, byte-addressed, 16-bit instruction memory read port and buffers fetched words in a small prefetch FIFO. It sits between the instruction memory and decode. It keeps a fetch PC, issues one read per cycle while buffer space exists, and hands {instruction, PC} pairs to decode over a valid/ready handshake. It also supports a redirect (branch/jump flush) and a halt.

---
 rtl/inst_fetch_unit.sv | 69 ++++++
 tb/tb_inst_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: walks a fetch PC over a single-cycle 16-bit memory
// and queues {instruction, PC} pairs in a small prefetch FIFO for decode.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_enable,
    output logic                       mem_wr,
    input  logic [15:0]                mem_data,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    input  logic                       halt,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [15:0]                inst_out,
    output logic [ADDR_WIDTH-1:0]      inst_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         cnt;
    logic [15:0]           fifo_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic                  push, pop;

    // Issue ignores inst_ready so the decode handshake never reaches the memory path.
    assign mem_enable = ~rst & ~halt & ~redirect_valid & (cnt < CW'(DEPTH));
    assign mem_wr     = 1'b0;
    assign mem_addr   = rst ? '0 : fetch_pc;
    assign push       = mem_enable;

    assign inst_valid = ~rst & (cnt != '0);
    assign pop        = inst_valid & inst_ready;
    assign inst_out   = inst_valid ? fifo_inst[head] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[head]   : '0;
    assign count      = rst ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ~ADDR_WIDTH'(1);
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any pop presented in the same cycle.
            fetch_pc <= redirect_pc & ~ADDR_WIDTH'(1);
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                fifo_inst[tail] <= mem_data;
                fifo_pc[tail]   <= fetch_pc;
                tail            <= tail + PW'(1);
                fetch_pc        <= fetch_pc + ADDR_WIDTH'(2);
            end
            if (pop)
                head <= head + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, backpressure, redirect, wrap, halt, reset.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_wr(mem_wr), .mem_data(mem_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .count(count)
    );

    // Memory image: the four preloaded words, a fixed pattern elsewhere.
    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: memf = 16'h1111;
            16'h0002: memf = 16'h2222;
            16'h0004: memf = 16'h3333;
            16'h0006: memf = 16'h4444;
            default:  memf = a ^ 16'h5A5A;
        endcase
    endfunction

    assign mem_data = memf(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_inst"},  32'(inst_out),   32'(memf(pc)));
        chk({tag, "_pc"},    32'(inst_pc),    32'(pc));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},    32'(mem_enable), 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"},  32'(inst_out),   32'd0);
        chk({tag, "_pc"},    32'(inst_pc),    32'd0);
        chk({tag, "_cnt"},   32'(count),      32'd0);
        chk({tag, "_addr"},  32'(mem_addr),   32'd0);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b0;
        tick(); tick(); settle();
        chk_zero("reset");
        chk("reset_wr", 32'(mem_wr), 32'd0);

        // Streaming with decode always ready
        rst = 1'b0; inst_ready = 1'b1; settle();
        chk("stream_first_en", 32'(mem_enable), 32'd1);
        chk("stream_first_addr", 32'(mem_addr), 32'd0);
        chk("stream_first_valid", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk_head($sformatf("stream%0d", k), 16'(2 * k));
            chk($sformatf("stream%0d_cnt", k), 32'(count), 32'd1);
        end

        // Backpressure to full
        rst = 1'b1; inst_ready = 1'b0;
        tick(); settle();
        rst = 1'b0; settle();
        chk("bp_first_en", 32'(mem_enable), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        settle();
        chk("bp_full_cnt", 32'(count), 32'd4);
        chk("bp_full_en", 32'(mem_enable), 32'd0);
        chk("bp_full_addr", 32'(mem_addr), 32'h0008);
        chk_head("bp_full_head", 16'h0000);
        tick(); settle();
        chk("bp_hold_addr", 32'(mem_addr), 32'h0008);
        chk_head("bp_hold_head", 16'h0000);
        inst_ready = 1'b1; settle();
        chk("bp_pop_full_en", 32'(mem_enable), 32'd0);
        tick(); settle();
        chk("bp_cnt3", 32'(count), 32'd3);
        chk("bp_resume_en", 32'(mem_enable), 32'd1);
        chk("bp_resume_addr", 32'(mem_addr), 32'h0008);
        chk_head("bp_drain1", 16'h0002);
        tick(); settle(); chk_head("bp_drain2", 16'h0004);
        tick(); settle(); chk_head("bp_drain3", 16'h0006);
        tick(); settle(); chk_head("bp_drain4", 16'h0008);
        chk("bp_drain4_cnt", 32'(count), 32'd3);

        // Redirect flush with count=3, pop presented in the same cycle
        redirect_valid = 1'b1; redirect_pc = 16'h0041; settle();
        chk("rd_cycle_en", 32'(mem_enable), 32'd0);
        tick(); redirect_valid = 1'b0; settle();
        chk("rd_cnt", 32'(count), 32'd0);
        chk("rd_valid", 32'(inst_valid), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'h0040);
        chk("rd_en", 32'(mem_enable), 32'd1);
        tick(); settle();
        chk_head("rd_head", 16'h0040);

        // Address wrap
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick(); redirect_valid = 1'b0; settle();
        chk("wrap_addr", 32'(mem_addr), 32'hFFFE);
        tick(); settle();
        chk_head("wrap_head0", 16'hFFFE);
        chk("wrap_next_addr", 32'(mem_addr), 32'h0000);
        tick(); settle();
        chk_head("wrap_head1", 16'h0000);

        // Halt with two entries queued
        inst_ready = 1'b0;
        tick(); settle();
        chk("halt_pre_cnt", 32'(count), 32'd2);
        halt = 1'b1; inst_ready = 1'b1; settle();
        chk("halt_en", 32'(mem_enable), 32'd0);
        tick(); settle();
        chk_head("halt_drain", 16'h0002);
        chk("halt_drain_cnt", 32'(count), 32'd1);
        tick(); settle();
        chk("halt_empty_cnt", 32'(count), 32'd0);
        chk("halt_empty_valid", 32'(inst_valid), 32'd0);
        chk("halt_held_addr", 32'(mem_addr), 32'h0004);
        halt = 1'b0; settle();
        chk("halt_resume_en", 32'(mem_enable), 32'd1);
        tick(); settle();
        chk_head("halt_resume_head", 16'h0004);

        // Reset mid-run with three entries, redirect also raised during reset
        inst_ready = 1'b0;
        tick(); tick(); settle();
        chk("mid_pre_cnt", 32'(count), 32'd3);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h1234;
        tick(); settle();
        chk_zero("mid_rst");
        rst = 1'b0; redirect_valid = 1'b0; settle();
        chk("mid_after_en", 32'(mem_enable), 32'd1);
        chk("mid_after_addr", 32'(mem_addr), 32'h0000);
        chk("mid_after_cnt", 32'(count), 32'd0);
        tick(); settle();
        chk_head("mid_after_head", 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
